requant_pipe: RTL and testbench
===============================

REQUANT_PIPE -- requirements
Module: requant_pipe

Interface
REQ-001 Parameter ACC_W, default 32, signed accumulator width.
REQ-002 Parameter OUT_W, default 8, unsigned output code width.
REQ-003 Parameter M_W, default 10, unsigned multiplier width.
REQ-004 Parameters M_SIG / M_TANH, defaults 24 / 48, accumulator multipliers per mode.
REQ-005 Parameter SH_ACC, default 14, accumulator right-shift; 2^14 = 128*128 weight*data scale.
REQ-006 Parameters MB_SIG / MB_TANH, defaults 24 / 48, bias multipliers per mode.
REQ-007 Parameter SH_B, default 8, bias right-shift; 2^8 = bias scale 256.
REQ-008 Parameter ZB, default 0, bias zero point.
REQ-009 Parameters Z_SIG / Z_TANH, defaults 128 / 128, output zero points.
REQ-010 Parameter CNT_W, default 16, saturation-counter width.
REQ-011 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-012 Port rst, input, 1, synchronous active-high reset.
REQ-013 Port in_valid, input, 1, input beat valid.
REQ-014 Port in_ready, output, 1, block accepts beat this cycle.
REQ-015 Port in_acc, input, ACC_W, signed inner-product sum.
REQ-016 Port in_bias, input, OUT_W, unsigned bias code.
REQ-017 Port in_mode, input, 1, 0 = sigmoid domain, 1 = tanh domain.
REQ-018 Port out_valid, output, 1, output beat valid.
REQ-019 Port out_ready, input, 1, downstream accepts beat.
REQ-020 Port out_code, output, OUT_W, saturated requantised code.
REQ-021 Port out_sat, output, 1, beat was clipped (low or high).
REQ-022 Port sat_cnt, output, CNT_W, count of clipped beats delivered.
REQ-023 Port sat_clr, input, 1, synchronous clear of sat_cnt.

Function
REQ-024 Two-stage pipeline S1, S2, each with a valid bit; in_mode travels with data.
REQ-025 Pipeline advances when out_ready=1 or S2 empty; in_ready = advance (combinational, no other dependency on in_valid).
REQ-026 Input accepted when in_valid && in_ready; latency 2 cycles from acceptance to out_valid with no stall; throughput 1 beat/cycle.
REQ-027 S1 registers pa = in_acc * M(mode) and pb = (in_bias - ZB) * MB(mode), signed, full width (ACC_W+M_W+1), no overflow.
REQ-028 S2 computes u = (pa >>> SH_ACC) + (pb >>> SH_B) + Z(mode); arithmetic shift (floor, toward -inf), sign-extended, no intermediate wrap.
REQ-029 S2 clips: u<0 -> 0; u>2^OUT_W-1 -> 2^OUT_W-1; else u[OUT_W-1:0]; out_sat = 1 iff clipped.
REQ-030 out_code, out_sat held stable while out_valid && !out_ready.
REQ-031 Stall: no beat dropped or duplicated; S1 and S2 hold while advance=0.
REQ-032 sat_cnt increments when out_valid && out_ready && out_sat; saturates at 2^CNT_W-1, no wrap.
REQ-033 sat_clr same cycle as an increment: clear wins, sat_cnt = 0.
REQ-034 No combinational path from in_* to out_*.

Reset
REQ-035 rst clears S1/S2 valid bits; out_valid=0, out_code=0, out_sat=0, sat_cnt=0 next cycle.
REQ-036 Reset mid-operation discards in-flight beats; in_ready=1 on the cycle after rst deasserts.
REQ-037 Beat presented during rst is not accepted.

Verification
REQ-038 Sigmoid, in_acc=16384, in_bias=0, out_ready=1 -> out_code=152, out_sat=0, 2 cycles later.
REQ-039 Tanh, in_acc=16384, in_bias=0 -> 176; sigmoid, in_acc=-1, in_bias=0 -> 127 (floor, not truncate).
REQ-040 Sigmoid, in_acc=163840 -> 255, out_sat=1; in_acc=-163840 -> 0, out_sat=1; sat_cnt=2 after both delivered.
REQ-041 Back-to-back 8 beats, out_ready low 3 cycles mid-stream -> in_ready low during stall, all 8 outputs in order, none lost.
REQ-042 sat_clr and a saturating delivery in the same cycle -> sat_cnt=0; sat_cnt at max plus another clip -> stays max.
REQ-043 rst asserted with 2 beats in flight -> out_valid=0 next cycle; no stale beat after release.

Source files
------------

// File: rtl/requant_pipe_if.sv
// requant_pipe_if: stream-in/stream-out bus of the requantiser, master = upstream/downstream driver, slave = requant_pipe
interface requant_pipe_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  logic in_valid, in_ready, in_mode, out_valid, out_ready, out_sat, sat_clr;
  logic [ACC_W-1:0] in_acc;
  logic [OUT_W-1:0] in_bias, out_code;
  logic [CNT_W-1:0] sat_cnt;
  modport master(
    output in_valid, in_acc, in_bias, in_mode, out_ready, sat_clr,
    input in_ready, out_valid, out_code, out_sat, sat_cnt
  );
  modport slave(
    input in_valid, in_acc, in_bias, in_mode, out_ready, sat_clr,
    output in_ready, out_valid, out_code, out_sat, sat_cnt
  );
endinterface

// File: rtl/requant_pipe.sv
// requant_pipe: two-stage requantiser, scaled acc + scaled bias + zero point, clipped to an unsigned code with a clip counter
module requant_pipe #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int M_W = 10,
  parameter int M_SIG = 24,
  parameter int M_TANH = 48,
  parameter int SH_ACC = 14,
  parameter int MB_SIG = 24,
  parameter int MB_TANH = 48,
  parameter int SH_B = 8,
  parameter int ZB = 0,
  parameter int Z_SIG = 128,
  parameter int Z_TANH = 128,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  requant_pipe_if.slave b
);
  localparam int PW = ACC_W + M_W + 1;
  localparam logic signed [PW:0] U_MAX = (PW+1)'((1 << OUT_W) - 1);
  logic w_adv, w_lo, w_hi, r1_v, r1_mode, r2_v, r2_sat;
  logic [M_W-1:0] w_m, w_mb;
  logic signed [PW-1:0] w_pa, w_pb, r1_pa, r1_pb;
  logic signed [PW:0] w_u;
  logic [OUT_W-1:0] r2_code;
  logic [CNT_W-1:0] r_cnt;
  assign w_adv = b.out_ready || !r2_v;
  assign w_m = b.in_mode ? M_W'(M_TANH) : M_W'(M_SIG);
  assign w_mb = b.in_mode ? M_W'(MB_TANH) : M_W'(MB_SIG);
  assign w_pa = PW'($signed(b.in_acc)) * $signed(PW'({1'b0, w_m}));
  assign w_pb = ($signed(PW'({1'b0, b.in_bias})) - PW'(ZB)) * $signed(PW'({1'b0, w_mb}));
  assign w_u = (PW+1)'(r1_pa >>> SH_ACC) + (PW+1)'(r1_pb >>> SH_B) + (PW+1)'(r1_mode ? Z_TANH : Z_SIG);
  assign w_lo = w_u[PW];
  assign w_hi = w_u > U_MAX;
  assign b.in_ready = w_adv;
  assign b.out_valid = r2_v;
  assign b.out_code = r2_code;
  assign b.out_sat = r2_sat;
  assign b.sat_cnt = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v <= 1'b0;
      r1_mode <= 1'b0;
      r1_pa <= '0;
      r1_pb <= '0;
      r2_v <= 1'b0;
      r2_code <= '0;
      r2_sat <= 1'b0;
    end else if (w_adv) begin
      r1_v <= b.in_valid;
      r1_mode <= b.in_mode;
      r1_pa <= w_pa;
      r1_pb <= w_pb;
      r2_v <= r1_v;
      r2_code <= w_lo ? '0 : w_hi ? '1 : w_u[OUT_W-1:0];
      r2_sat <= r1_v && (w_lo || w_hi);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || b.sat_clr) r_cnt <= '0;
    else if (r2_v && b.out_ready && r2_sat && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: tb/tb_requant_pipe.sv
// tb_requant_pipe: random and directed stimulus checked against an arithmetic reference of the requantiser
module tb_requant_pipe;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  requant_pipe_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus();
  requant_pipe #(.ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut(.clk(clk), .rst(rst), .b(bus.slave));
  int total = 0;
  int bad = 0;
  int delivered = 0;
  int m_cnt = 0;
  logic [8:0] q[$];
  bit prev_stall = 0;
  logic [8:0] prev_out = '0;
  function automatic longint fdiv(longint a, longint d);
    longint r = a / d;
    if (a % d != 0 && a < 0) r--;
    return r;
  endfunction
  function automatic logic [8:0] ref_model(int acc, int bias, bit mode);
    longint u = fdiv(longint'(acc) * (mode ? 48 : 24), 16384) + fdiv(longint'(bias) * (mode ? 48 : 24), 256) + 128;
    if (u < 0) return {1'b1, 8'd0};
    if (u > 255) return {1'b1, 8'd255};
    return {1'b0, 8'(u)};
  endfunction
  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [8:0] e;
    bit sat_deliv;
    sat_deliv = 0;
    if (!rst) chk("in_ready", bus.in_ready, bus.out_ready || !bus.out_valid);
    chk("sat_cnt", bus.sat_cnt, m_cnt);
    if (prev_stall && !rst) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", {bus.out_sat, bus.out_code}, prev_out);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_beat: got code %0d want no beat", bus.out_code);
      end else begin
        e = q.pop_front();
        chk("out", {bus.out_sat, bus.out_code}, e);
        sat_deliv = e[8];
        delivered++;
      end
    end
    if (rst || bus.sat_clr) m_cnt = 0;
    else if (sat_deliv && m_cnt < CMAX) m_cnt++;
    prev_stall = !rst && bus.out_valid && !bus.out_ready;
    prev_out = {bus.out_sat, bus.out_code};
    if (rst) q.delete();
    else if (bus.in_valid && bus.in_ready) q.push_back(ref_model($signed(bus.in_acc), int'(bus.in_bias), bus.in_mode));
  end
  task automatic send(int acc, int bias, bit mode);
    bus.in_valid = 1'b1;
    bus.in_acc = acc;
    bus.in_bias = 8'(bias);
    bus.in_mode = mode;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (i > 1000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got no in_ready want accept");
        break;
      end
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic lit(string n, int acc, int bias, bit mode, int code, bit sat);
    send(acc, bias, mode);
    chk({n, "_early"}, bus.out_valid, 0);
    @(posedge clk);
    #1;
    chk({n, "_valid"}, bus.out_valid, 1);
    chk(n, {bus.out_sat, bus.out_code}, {sat, 8'(code)});
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    int d0;
    int a;
    bit took;
    bus.in_valid = 0;
    bus.in_acc = '0;
    bus.in_bias = '0;
    bus.in_mode = 0;
    bus.out_ready = 1;
    bus.sat_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_code", bus.out_code, 0);
    chk("rst_sat", bus.out_sat, 0);
    chk("rst_cnt", bus.sat_cnt, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("model152", ref_model(16384, 0, 0), 152);
    chk("model127", ref_model(-1, 0, 0), 127);
    chk("model_bias", ref_model(0, 255, 0), 151);
    @(posedge clk);
    #1;
    lit("sig152", 16384, 0, 0, 152, 0);
    lit("tanh176", 16384, 0, 1, 176, 0);
    lit("floor127", -1, 0, 0, 127, 0);
    lit("bias151", 0, 255, 0, 151, 0);
    lit("hi255", 163840, 0, 0, 255, 1);
    lit("lo0", -163840, 0, 0, 0, 1);
    @(posedge clk);
    #1 chk("satcnt2", bus.sat_cnt, 2);
    d0 = delivered;
    fork
      for (int i = 0; i < 8; i++) send(i * 5000 - 20000, i * 30, i[0]);
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    repeat (5) @(posedge clk);
    #1 chk("stall8", delivered - d0, 8);
    for (int i = 0; i < 20; i++) send(200000, 0, 0);
    repeat (4) @(posedge clk);
    #1 chk("satmax", bus.sat_cnt, CMAX);
    send(200000, 0, 0);
    for (int i = 0; i < 10 && !bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    bus.sat_clr = 1;
    @(posedge clk);
    #1 bus.sat_clr = 0;
    chk("clr_wins", bus.sat_cnt, 0);
    send(1000, 0, 0);
    send(2000, 0, 1);
    rst = 1;
    bus.in_valid = 1;
    bus.in_acc = 3000;
    @(posedge clk);
    #1;
    chk("rst_flush", bus.out_valid, 0);
    rst = 0;
    bus.in_valid = 0;
    @(negedge clk);
    chk("rst_release_ready", bus.in_ready, 1);
    repeat (5) @(posedge clk);
    #1 chk("rst_no_stale", bus.out_valid, 0);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (took || !bus.in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          a = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 400000)) - 200000;
          bus.in_valid = 1;
          bus.in_acc = a;
          bus.in_bias = 8'($urandom_range(0, 255));
          bus.in_mode = 1'($urandom_range(0, 1));
        end else bus.in_valid = 0;
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.sat_clr = $urandom_range(0, 40) == 0;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.sat_clr = 0;
    repeat (10) @(posedge clk);
    #1 chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
